cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL provide parameter RST_HOLD, default 5, number of clk cycles cpu_rst stays asserted after rst deasserts (range 1..255).
REQ-002 SHALL provide parameter ADDR_W, default 32, width of snooped address and PC.
REQ-003 SHALL provide parameter DATA_W, default 32, width of snooped write data.
REQ-004 SHALL provide parameter MBOX_ADDR, default 32'hFFFF_FFF0, mailbox address.
REQ-005 SHALL provide parameter PASS_CODE, default 32'h0000_600D, mailbox value meaning pass.
REQ-006 SHALL provide parameter TIMEOUT, default 10000, maximum RUN cycles (1..2^CNT_W-1).
REQ-007 SHALL provide parameter HALT_CYCLES, default 16, consecutive identical valid PCs that mean halt (2..255).
REQ-008 SHALL provide parameter CNT_W, default 32, width of both counters.
REQ-009 SHALL have ports: clk input 1 system clock; rst input 1 reset; cpu_rst output 1 reset to CPU; mem_we input 1 CPU data write strobe; mem_addr input ADDR_W write address; mem_wdata input DATA_W write data; pc input ADDR_W CPU program counter; pc_valid input 1 one-cycle strobe at instruction fetch; state output 3 FSM encoding; done output 1 run finished; pass output 1; fail output 1; timed_out output 1; halted output 1; cycle_count output CNT_W; instr_count output CNT_W.
REQ-010 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-011 SHALL implement FSM states HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HALT=5, driven on state.
REQ-012 HOLD: cpu_rst=1; internal hold counter increments each clk; after exactly RST_HOLD cycles following rst deassertion, transition to RUN and drive cpu_rst=0 (registered).
REQ-013 RUN: cycle_count increments by 1 every clk; instr_count increments by 1 on each cycle with pc_valid=1.
REQ-014 RUN: mem_we=1 and mem_addr==MBOX_ADDR and mem_wdata==PASS_CODE -> PASS next cycle.
REQ-015 RUN: mem_we=1 and mem_addr==MBOX_ADDR and mem_wdata!=PASS_CODE -> FAIL next cycle.
REQ-016 RUN: pc_valid=1 with pc equal to previous valid pc SHALL increment a repeat counter; different pc resets it to 0; when repeat counter reaches HALT_CYCLES-1 -> HALT next cycle.
REQ-017 RUN: cycle_count reaching TIMEOUT-1 with no other exit -> TIMEOUT next cycle (exactly TIMEOUT RUN cycles counted).
REQ-018 Priority on simultaneous events in one cycle: mailbox (PASS/FAIL) > HALT > TIMEOUT.
REQ-019 PASS, FAIL, TIMEOUT, HALT are terminal; only rst exits them; counters freeze; cpu_rst re-asserts to 1 to stop the CPU.
REQ-020 done=1 in any terminal state; pass, fail, timed_out, halted each 1 only in their matching state; all decoded from registered state.
REQ-021 Counters SHALL saturate at all-ones, never wrap.
REQ-022 pc_valid and mem_we SHALL be ignored outside RUN.
REQ-023 First pc_valid after entering RUN SHALL only load the previous-pc register, repeat counter stays 0.

Reset
REQ-024 rst=1 SHALL asynchronously force state=HOLD, cpu_rst=1, done/pass/fail/timed_out/halted=0, cycle_count=0, instr_count=0, hold and repeat counters 0, previous-pc register 0.
REQ-025 rst asserted mid-RUN or in a terminal state SHALL abort immediately with the same values; HOLD sequence restarts on deassertion.
REQ-026 rst deassertion SHALL be sampled on the clk rising edge; no output changes except via registers.

Verification
REQ-027 rst high 50 ns then low, RST_HOLD=5, 10 ns clk -> cpu_rst falls on the 5th rising edge after release, state=RUN.
REQ-028 In RUN after 100 cycles, write 32'h0000_600D to 32'hFFFF_FFF0 -> next cycle state=PASS, done=1, pass=1, cycle_count frozen at 101, cpu_rst=1.
REQ-029 Write 32'hDEAD_BEEF to MBOX_ADDR on the same cycle the halt repeat count completes -> FAIL, halted=0.
REQ-030 pc_valid every cycle with pc fixed at 32'h40 -> HALT after 16 strobes, instr_count=16.
REQ-031 TIMEOUT=50, no mailbox write, changing pc -> timed_out=1 with cycle_count=50; then rst pulse mid-terminal -> all outputs return to reset values asynchronously.
REQ-032 CNT_W=4, TIMEOUT=15, 20 pc_valid strobes before timeout impossible; verify instr_count saturates at 15 and does not wrap.

Source files
------------

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - CPU run controller: reset sequencing and run-outcome detection
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   cpu_rst               registered reset to the CPU (released after RST_HOLD cycles, re-asserted at end of run)
//   mem_we/mem_addr/mem_wdata  snooped CPU data write (mailbox detection)
//   pc/pc_valid           snooped program counter and fetch strobe (halt detection, instruction count)
//   state                 FSM encoding: HOLD=0 RUN=1 PASS=2 FAIL=3 TIMEOUT=4 HALT=5
//   done/pass/fail/timed_out/halted  run outcome flags decoded from registered state
//   cycle_count/instr_count  saturating RUN cycle and fetched-instruction counters

module cpu_run_controller #(
    parameter int                RST_HOLD    = 5,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] MBOX_ADDR   = ADDR_W'(32'hFFFF_FFF0),
    parameter logic [DATA_W-1:0] PASS_CODE   = DATA_W'(32'h0000_600D),
    parameter int                TIMEOUT     = 10000,
    parameter int                HALT_CYCLES = 16,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cpu_rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic [2:0]        state,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(RST_HOLD - 1);
    // Repeat count before the increment that completes the halt run.
    localparam logic [7:0]       REP_LAST  = 8'(HALT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    logic               r_cpu_rst;
    logic [7:0]         r_hold_cnt;
    logic [7:0]         r_rep_cnt;
    logic [ADDR_W-1:0]  r_prev_pc;
    logic               r_pc_seen;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   r_instr_count;

    logic w_mbox_hit;
    logic w_pass_code;
    logic w_pc_repeat;
    logic w_halt_hit;
    logic w_tmo_hit;

    assign w_mbox_hit  = mem_we && (mem_addr == MBOX_ADDR);
    assign w_pass_code = (mem_wdata == PASS_CODE);
    // r_pc_seen guards against treating the reset value of r_prev_pc as a real fetch.
    assign w_pc_repeat = pc_valid && r_pc_seen && (pc == r_prev_pc);
    assign w_halt_hit  = w_pc_repeat && (r_rep_cnt == REP_LAST);
    assign w_tmo_hit   = (r_cycle_count == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HOLD;
            r_cpu_rst     <= 1'b1;
            r_hold_cnt    <= '0;
            r_rep_cnt     <= '0;
            r_prev_pc     <= '0;
            r_pc_seen     <= 1'b0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= ST_RUN;
                        r_cpu_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The exit cycle itself is counted, so a timeout freezes at exactly TIMEOUT.
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + CNT_ONE;
                    end
                    if (pc_valid) begin
                        if (r_instr_count != '1) begin
                            r_instr_count <= r_instr_count + CNT_ONE;
                        end
                        r_pc_seen <= 1'b1;
                        r_prev_pc <= pc;
                        if (w_pc_repeat) begin
                            r_rep_cnt <= r_rep_cnt + 8'd1;
                        end else begin
                            r_rep_cnt <= '0;
                        end
                    end
                    // Mailbox outranks halt, halt outranks timeout.
                    if (w_mbox_hit) begin
                        r_state   <= w_pass_code ? ST_PASS : ST_FAIL;
                        r_cpu_rst <= 1'b1;
                    end else if (w_halt_hit) begin
                        r_state   <= ST_HALT;
                        r_cpu_rst <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_TIMEOUT;
                        r_cpu_rst <= 1'b1;
                    end
                end
                default: begin
                    // Terminal states: everything frozen until rst.
                end
            endcase
        end
    end

    assign cpu_rst     = r_cpu_rst;
    assign state       = r_state;
    assign done        = (r_state == ST_PASS) || (r_state == ST_FAIL) ||
                         (r_state == ST_TIMEOUT) || (r_state == ST_HALT);
    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign timed_out   = (r_state == ST_TIMEOUT);
    assign halted      = (r_state == ST_HALT);
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed self-checking bench for cpu_run_controller

module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic        pc_valid;

    logic        a_cpu_rst, a_done, a_pass, a_fail, a_tmo, a_halt;
    logic [2:0]  a_state;
    logic [31:0] a_cyc, a_ins;
    logic        b_cpu_rst, b_done, b_pass, b_fail, b_tmo, b_halt;
    logic [2:0]  b_state;
    logic [31:0] b_cyc, b_ins;
    logic        c_cpu_rst, c_done, c_pass, c_fail, c_tmo, c_halt;
    logic [2:0]  c_state;
    logic [3:0]  c_cyc, c_ins;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_run_controller u_dut (
        .clk(clk), .rst(rst_a), .cpu_rst(a_cpu_rst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .pc_valid(pc_valid), .state(a_state), .done(a_done),
        .pass(a_pass), .fail(a_fail), .timed_out(a_tmo), .halted(a_halt),
        .cycle_count(a_cyc), .instr_count(a_ins)
    );

    cpu_run_controller #(.TIMEOUT(50)) u_tmo (
        .clk(clk), .rst(rst_b), .cpu_rst(b_cpu_rst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .pc_valid(pc_valid), .state(b_state), .done(b_done),
        .pass(b_pass), .fail(b_fail), .timed_out(b_tmo), .halted(b_halt),
        .cycle_count(b_cyc), .instr_count(b_ins)
    );

    cpu_run_controller #(.CNT_W(4), .TIMEOUT(15)) u_sat (
        .clk(clk), .rst(rst_c), .cpu_rst(c_cpu_rst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .pc_valid(pc_valid), .state(c_state), .done(c_done),
        .pass(c_pass), .fail(c_fail), .timed_out(c_tmo), .halted(c_halt),
        .cycle_count(c_cyc), .instr_count(c_ins)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        pc        = 32'h0;
        pc_valid  = 1'b0;
    endtask

    // Pulse rst_a between edges and wait out the RST_HOLD=5 sequence.
    task automatic restart_a();
        #2 rst_a = 1'b1;
        #1 check_eq("async_rst_state", a_state, 3'd0);
        check_eq("async_rst_cpu_rst", a_cpu_rst, 1'b1);
        check_eq("async_rst_cyc", a_cyc, 0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("restart_run", a_state, 3'd1);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        idle_inputs();

        // Reset values
        @(negedge clk);
        check_eq("rst_state", a_state, 3'd0);
        check_eq("rst_cpu_rst", a_cpu_rst, 1'b1);
        check_eq("rst_flags", {a_done, a_pass, a_fail, a_tmo, a_halt}, 5'b0);
        check_eq("rst_cyc", a_cyc, 0);
        check_eq("rst_ins", a_ins, 0);

        // Release at 50 ns; cpu_rst falls on the 5th rising edge afterwards
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("hold_4_edges_cpu_rst", a_cpu_rst, 1'b1);
        check_eq("hold_4_edges_state", a_state, 3'd0);
        @(negedge clk);
        check_eq("hold_5_edges_cpu_rst", a_cpu_rst, 1'b0);
        check_eq("hold_5_edges_state", a_state, 3'd1);
        check_eq("run_entry_cyc", a_cyc, 0);

        // 100 RUN cycles with changing pc; one write to a neighbouring address is not the mailbox
        for (int i = 0; i < 100; i++) begin
            pc       = 32'(i * 4);
            pc_valid = 1'b1;
            mem_we   = (i == 50);
            mem_addr = 32'hFFFF_FFF4;
            mem_wdata = 32'h0000_600D;
            @(negedge clk);
        end
        check_eq("run100_state", a_state, 3'd1);
        check_eq("run100_cyc", a_cyc, 100);
        check_eq("run100_ins", a_ins, 100);
        pc_valid  = 1'b0;
        mem_we    = 1'b1;
        mem_addr  = 32'hFFFF_FFF0;
        mem_wdata = 32'h0000_600D;
        @(negedge clk);
        check_eq("pass_state", a_state, 3'd2);
        check_eq("pass_flags", {a_done, a_pass, a_fail, a_tmo, a_halt}, 5'b11000);
        check_eq("pass_cyc", a_cyc, 101);
        check_eq("pass_cpu_rst", a_cpu_rst, 1'b1);
        // Terminal: a failing write and fetches are ignored, counters frozen
        mem_wdata = 32'hDEAD_BEEF;
        pc_valid  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pass_sticky_state", a_state, 3'd2);
        check_eq("pass_frozen_cyc", a_cyc, 101);
        check_eq("pass_frozen_ins", a_ins, 100);
        idle_inputs();

        // Mailbox fail beats a halt completing on the same cycle.
        // Fetches during HOLD must be ignored (no count, no pc load).
        pc       = 32'h40;
        pc_valid = 1'b1;
        restart_a();
        check_eq("hold_ignores_fetch", a_ins, 0);
        repeat (15) @(negedge clk);
        check_eq("fail_pre_state", a_state, 3'd1);
        mem_we    = 1'b1;
        mem_addr  = 32'hFFFF_FFF0;
        mem_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("fail_state", a_state, 3'd3);
        check_eq("fail_flags", {a_done, a_pass, a_fail, a_tmo, a_halt}, 5'b10100);
        check_eq("fail_ins", a_ins, 16);
        idle_inputs();

        // Fixed pc 0x40 on every cycle: HALT after 16 strobes
        restart_a();
        pc       = 32'h40;
        pc_valid = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("halt_15_state", a_state, 3'd1);
        @(negedge clk);
        check_eq("halt_state", a_state, 3'd5);
        check_eq("halt_flags", {a_done, a_pass, a_fail, a_tmo, a_halt}, 5'b10001);
        check_eq("halt_ins", a_ins, 16);
        check_eq("halt_cyc", a_cyc, 16);
        check_eq("halt_cpu_rst", a_cpu_rst, 1'b1);
        idle_inputs();
        rst_a = 1'b1;

        // TIMEOUT=50 with changing pc
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("tmo_run", b_state, 3'd1);
        for (int i = 0; i < 49; i++) begin
            pc       = 32'h1000 + 32'(i * 4);
            pc_valid = 1'b1;
            @(negedge clk);
        end
        check_eq("tmo_49_state", b_state, 3'd1);
        pc = 32'h2000;
        @(negedge clk);
        check_eq("tmo_state", b_state, 3'd4);
        check_eq("tmo_flags", {b_done, b_pass, b_fail, b_tmo, b_halt}, 5'b10010);
        check_eq("tmo_cyc", b_cyc, 50);
        check_eq("tmo_ins", b_ins, 50);
        repeat (2) @(negedge clk);
        check_eq("tmo_frozen_cyc", b_cyc, 50);
        #2 rst_b = 1'b1;
        #1 check_eq("tmo_abort_state", b_state, 3'd0);
        check_eq("tmo_abort_flags", {b_done, b_pass, b_fail, b_tmo, b_halt}, 5'b0);
        check_eq("tmo_abort_cpu_rst", b_cpu_rst, 1'b1);
        check_eq("tmo_abort_cyc", b_cyc, 0);
        check_eq("tmo_abort_ins", b_ins, 0);
        @(negedge clk);
        idle_inputs();

        // CNT_W=4, TIMEOUT=15: 20 strobes offered, counters end at 15 without wrapping
        rst_c = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("sat_run", c_state, 3'd1);
        for (int i = 0; i < 20; i++) begin
            pc       = 32'h100 + 32'(i * 4);
            pc_valid = 1'b1;
            @(negedge clk);
            if (i == 13) check_eq("sat_14_state", c_state, 3'd1);
        end
        check_eq("sat_state", c_state, 3'd4);
        check_eq("sat_ins", c_ins, 4'd15);
        check_eq("sat_cyc", c_cyc, 4'd15);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
